// File: rtl/alu.sv
// alu: 8-bit CPU ALU, combinational core with registered result and flags.
// Optional macro ALU_ROTATE_EN: enables ROL/ROR (otherwise they act as PASS).
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             master_clk,
  input  logic             reset_n,
  input  logic [3:0]       oper,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       proc_flags_in,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       proc_flags_out
);

  localparam int M = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBC  = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_LSL  = 4'd8;
  localparam logic [3:0] OP_LSR  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_NOT  = 4'd13;
  localparam logic [3:0] OP_NEG  = 4'd14;

  logic             cin;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_c;
  logic [WIDTH:0]   sum;
  logic             ovf;

  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] zn_src;
  logic             c_nxt;
  logic             v_nxt;
  logic             keep;
  logic [3:0]       fl_nxt;

  assign cin = proc_flags_in[1];

  // One shared adder; subtraction feeds ~b with the appropriate carry-in
  always_comb begin
    add_a = a_in;
    add_b = b_in;
    add_c = 1'b0;
    case (oper)
      OP_ADC: add_c = cin;
      OP_SUB,
      OP_CMP: begin
        add_b = ~b_in;
        add_c = 1'b1;
      end
      OP_SBC: begin
        add_b = ~b_in;
        add_c = cin;
      end
      OP_NEG: begin
        add_a = '0;
        add_b = ~a_in;
        add_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum = {1'b0, add_a} + {1'b0, add_b}
             + {{WIDTH{1'b0}}, add_c};

  // With ~b applied, one same-sign test covers add and subtract
  assign ovf = (add_a[M] == add_b[M]) &&
               (sum[M] != add_a[M]);

  always_comb begin
    res    = a_in;
    c_nxt  = cin;
    v_nxt  = proc_flags_in[2];
    keep   = 1'b0;
    case (oper)
      OP_ADD, OP_ADC,
      OP_SUB, OP_SBC,
      OP_NEG: begin
        res   = sum[M:0];
        c_nxt = sum[WIDTH];
        v_nxt = ovf;
      end
      OP_CMP: begin
        c_nxt = sum[WIDTH];
        v_nxt = ovf;
      end
      OP_AND: res = a_in & b_in;
      OP_OR:  res = a_in | b_in;
      OP_XOR: res = a_in ^ b_in;
      OP_NOT: res = ~a_in;
      OP_LSL: begin
        res   = {a_in[M-1:0], 1'b0};
        c_nxt = a_in[M];
      end
      OP_LSR: begin
        res   = {1'b0, a_in[M:1]};
        c_nxt = a_in[0];
      end
      OP_ASR: begin
        res   = {a_in[M], a_in[M:1]};
        c_nxt = a_in[0];
      end
`ifdef ALU_ROTATE_EN
      OP_ROL: begin
        res   = {a_in[M-1:0], cin};
        c_nxt = a_in[M];
      end
      OP_ROR: begin
        res   = {cin, a_in[M:1]};
        c_nxt = a_in[0];
      end
`endif
      default: keep = 1'b1;
    endcase
  end

  // CMP reports Z/N of the difference while passing a through
  assign zn_src = (oper == OP_CMP) ? sum[M:0] : res;

  assign fl_nxt = keep ? proc_flags_in
                       : {zn_src[M], v_nxt, c_nxt,
                          (zn_src == '0)};

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      out            <= '0;
      proc_flags_out <= 4'b0000;
    end else begin
      out            <= res;
      proc_flags_out <= fl_nxt;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu; expected {flags,out} queued at issue.
// Build with +define+ALU_ROTATE_EN to exercise the rotate opcodes.
module tb_alu;

  logic       master_clk;
  logic       reset_n;
  logic [3:0] oper;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [3:0] proc_flags_in;
  logic [7:0] out;
  logic [3:0] proc_flags_out;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  alu #(.WIDTH(8)) dut (
    .master_clk     (master_clk),
    .reset_n        (reset_n),
    .oper           (oper),
    .a_in           (a_in),
    .b_in           (b_in),
    .proc_flags_in  (proc_flags_in),
    .out            (out),
    .proc_flags_out (proc_flags_out)
  );

  initial master_clk = 1'b0;
  always #5 master_clk = ~master_clk;

  task automatic check(string tag, logic [11:0] got,
                       logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got flags=%b out=%h, expected flags=%b out=%h",
               tag, got[11:8], got[7:0], exp[11:8], exp[7:0]);
    end
  endtask

  // Independent reference using integer arithmetic
  function automatic logic [11:0] model(logic [3:0] op,
                                        logic [7:0] a,
                                        logic [7:0] b,
                                        logic [3:0] f);
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int ci = f[1];
    int r = 0;
    int sr = 0;
    logic [7:0] res = a;
    logic [7:0] zs;
    logic c = f[1];
    logic v = f[2];
    bit keep = 0;
    bit arith = 0;
    case (op)
      4'd0: begin r = ua + ub;      sr = sa + sb;      arith = 1; end
      4'd1: begin r = ua + ub + ci; sr = sa + sb + ci; arith = 1; end
      4'd2, 4'd4: begin r = ua - ub; sr = sa - sb; arith = 1; end
      4'd3: begin r = ua - ub - (1 - ci); sr = sa - sb - (1 - ci); arith = 1; end
      4'd14: begin r = 0 - ua; sr = 0 - sa; arith = 1; end
      4'd5: res = a & b;
      4'd6: res = a | b;
      4'd7: res = a ^ b;
      4'd13: res = ~a;
      4'd8: begin res = 8'(ua * 2); c = a[7]; end
      4'd9: begin res = 8'(ua / 2); c = a[0]; end
      4'd10: begin res = {a[7], a[7:1]}; c = a[0]; end
`ifdef ALU_ROTATE_EN
      4'd11: begin res = 8'(ua * 2 + ci); c = a[7]; end
      4'd12: begin res = 8'(ua / 2 + ci * 128); c = a[0]; end
`endif
      default: keep = 1;
    endcase
    if (arith) begin
      res = 8'(r);
      v = (sr > 127) || (sr < -128);
      c = (op <= 4'd1) ? (r > 255) : (r >= 0);
    end
    zs = res;
    if (op == 4'd4) res = a;
    if (keep) return {f, a};
    return {zs[7], v, c, (zs == 8'h00), res};
  endfunction

  task automatic issue(string tag, logic [3:0] op, logic [7:0] a,
                       logic [7:0] b, logic [3:0] f,
                       logic [11:0] exp);
    oper = op;
    a_in = a;
    b_in = b;
    proc_flags_in = f;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge master_clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 12'h001, 12'h000);
    end else begin
      check(tag_q.pop_front(), {proc_flags_out, out},
            exp_q.pop_front());
    end
  endtask

  task automatic issue_m(string tag, logic [3:0] op, logic [7:0] a,
                         logic [7:0] b, logic [3:0] f);
    issue(tag, op, a, b, f, model(op, a, b, f));
  endtask

  initial begin
    reset_n = 1'b1;
    oper = 4'd0;
    a_in = 8'h00;
    b_in = 8'h00;
    proc_flags_in = 4'b0000;
    #2 reset_n = 1'b0;
    #1 check("reset_async", {proc_flags_out, out}, 12'h000);
    oper = 4'd15;
    a_in = 8'hA5;
    proc_flags_in = 4'b1111;
    repeat (2) @(posedge master_clk);
    #1 check("reset_hold", {proc_flags_out, out}, 12'h000);
    @(negedge master_clk);
    reset_n = 1'b1;

    // Directed vectors with fixed expectations
    issue("add_ovf", 4'd0,  8'h7F, 8'h01, 4'b0000, {4'b1100, 8'h80});
    issue("adc_c",   4'd1,  8'hFF, 8'h00, 4'b0010, {4'b0011, 8'h00});
    issue("sub_brw", 4'd2,  8'h00, 8'h01, 4'b0000, {4'b1000, 8'hFF});
    issue("cmp_eq",  4'd4,  8'h05, 8'h05, 4'b0000, {4'b0011, 8'h05});
    issue("sbc",     4'd3,  8'h10, 8'h01, 4'b0000, {4'b0010, 8'h0E});
    issue("and_kp",  4'd5,  8'hF0, 8'h0F, 4'b0110, {4'b0111, 8'h00});
    issue("not",     4'd13, 8'h00, 8'h00, 4'b0000, {4'b1000, 8'hFF});
    issue("lsl_81",  4'd8,  8'h81, 8'h00, 4'b0000, {4'b0010, 8'h02});
    issue("asr_81",  4'd10, 8'h81, 8'h00, 4'b0000, {4'b1010, 8'hC0});
    issue("neg_01",  4'd14, 8'h01, 8'h00, 4'b0000, {4'b1000, 8'hFF});
    issue("neg_80",  4'd14, 8'h80, 8'h00, 4'b0000, {4'b1100, 8'h80});
    issue("pass",    4'd15, 8'h5A, 8'h33, 4'b1011, {4'b1011, 8'h5A});
`ifdef ALU_ROTATE_EN
    issue("rol",     4'd11, 8'h80, 8'h00, 4'b0010, {4'b0010, 8'h01});
    issue("ror",     4'd12, 8'h01, 8'h00, 4'b0000, {4'b0011, 8'h00});
`else
    issue("rol_pass", 4'd11, 8'h80, 8'h00, 4'b0010, {4'b0010, 8'h80});
    issue("ror_pass", 4'd12, 8'h01, 8'h00, 4'b0000, {4'b0000, 8'h01});
`endif

    // Shift sweeps, back-to-back every cycle
    for (int i = 0; i < 256; i++)
      issue_m("lsl_sweep", 4'd8, 8'(i), 8'h00, 4'(i));
    for (int i = 0; i < 256; i++)
      issue_m("lsr_sweep", 4'd9, 8'(i), 8'h00, 4'(i + 5));
    for (int i = 0; i < 256; i++)
      issue_m("asr_sweep", 4'd10, 8'(i), 8'h00, 4'(i * 3));

    for (int i = 0; i < 400; i++)
      issue_m("random", 4'($urandom), 8'($urandom),
              8'($urandom), 4'($urandom));

    // Mid-stream reset between edges
    oper = 4'd0;
    a_in = 8'h12;
    b_in = 8'h34;
    proc_flags_in = 4'b0000;
    #2 reset_n = 1'b0;
    #1 check("mid_reset", {proc_flags_out, out}, 12'h000);
    @(posedge master_clk);
    #1 check("mid_reset_hold", {proc_flags_out, out}, 12'h000);
    @(negedge master_clk);
    reset_n = 1'b1;
    issue("post_reset", 4'd0, 8'h12, 8'h34, 4'b0000, {4'b0000, 8'h46});
    issue_m("post_reset2", 4'd7, 8'hFF, 8'h0F, 4'b0100);

    if (exp_q.size() != 0)
      check("queue_drain", 12'(exp_q.size()), 12'h000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
